// File: rtl/clk_div_if.sv
// clk_div_if: control/status bundle for the programmable clock divider.
// Ports (master drives / slave drives):
//   enable, div_val[CNT_W], div_load          : master -> slave
//   div_ack, div_err, clk_out, rise_pulse,
//   fall_pulse, period_cnt[PCNT_W], busy       : slave -> master
interface clk_div_if #(
    parameter int CNT_W  = 8,
    parameter int PCNT_W = 16
);
    logic              enable;
    logic [CNT_W-1:0]  div_val;
    logic              div_load;
    logic              div_ack;
    logic              div_err;
    logic              clk_out;
    logic              rise_pulse;
    logic              fall_pulse;
    logic [PCNT_W-1:0] period_cnt;
    logic              busy;
    modport master (
        output enable, div_val, div_load,
        input  div_ack, div_err, clk_out, rise_pulse, fall_pulse, period_cnt, busy
    );
    modport slave (
        input  enable, div_val, div_load,
        output div_ack, div_err, clk_out, rise_pulse, fall_pulse, period_cnt, busy
    );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: glitch-free programmable clock divider with edge strobes and run-time ratio reload.
// Ports:
//   clk  : system clock, all logic on rising edge
//   rst  : synchronous active-high reset
//   bus  : clk_div_if.slave (enable, div_val, div_load in; div_ack, div_err,
//          clk_out, rise_pulse, fall_pulse, period_cnt, busy out)
module clk_div_gen #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int PCNT_W      = 16
) (
    input logic      clk,
    input logic      rst,
    clk_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t           state;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] pend_val;
    logic             pend_vld;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic             bnd;
    assign h = n_act >> 1;
    assign l = n_act - h;
    // A new ratio may only be applied when no period is in flight.
    assign bnd = (state == IDLE) || (state == LOW && cnt == l);
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n_act          <= CNT_W'(DEFAULT_DIV);
            pend_val       <= '0;
            pend_vld       <= 1'b0;
            cnt            <= '0;
            bus.clk_out    <= 1'b0;
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            bus.div_ack    <= 1'b0;
            bus.div_err    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.period_cnt <= '0;
        end else begin
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            bus.div_ack    <= 1'b0;
            bus.div_err    <= 1'b0;
            if (bnd && pend_vld) begin
                n_act       <= pend_val;
                bus.div_ack <= 1'b1;
                pend_vld    <= 1'b0;
            end
            // Placed after the apply so a load coinciding with a boundary stays pending.
            if (bus.div_load) begin
                if (bus.div_val >= CNT_W'(2)) begin
                    pend_val <= bus.div_val;
                    pend_vld <= 1'b1;
                end else begin
                    bus.div_err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state          <= HIGH;
                        bus.clk_out    <= 1'b1;
                        bus.rise_pulse <= 1'b1;
                        bus.busy       <= 1'b1;
                        cnt            <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == h) begin
                        state          <= LOW;
                        bus.clk_out    <= 1'b0;
                        bus.fall_pulse <= 1'b1;
                        cnt            <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt != l) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        bus.period_cnt <= bus.period_cnt + PCNT_W'(1);
                        if (bus.enable) begin
                            state          <= HIGH;
                            bus.clk_out    <= 1'b1;
                            bus.rise_pulse <= 1'b1;
                            cnt            <= CNT_W'(1);
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Programmable synchronous clock divider / clock-enable generator.
- Derives a slower clock (`clk_out`) and single-cycle edge strobes from the 100 MHz system clock. With the default ratio 2 it produces the 50 MHz companion clock consumed by the downstream dual-clock sampling stage.
- Ratio is reloadable at run time through a load/ack handshake. Each new ratio takes effect only at a period boundary, so `clk_out` never glitches.

Parameters:
- `CNT_W`, 8, width of divide ratio and phase counter.
- `DEFAULT_DIV`, 2, divide ratio after reset; must be >= 2.
- `PCNT_W`, 16, width of completed-period counter.

Ports:
- `clk`, in, 1, system clock (100 MHz); all logic on its rising edge.
- `rst`, in, 1, synchronous active-high reset.
- `enable`, in, 1, run request; 1 = generate clock, 0 = stop at next period boundary.
- `div_val`, in, `CNT_W`, requested divide ratio N.
- `div_load`, in, 1, one-cycle request to load `div_val`.
- `div_ack`, out, 1, one-cycle pulse when a loaded ratio becomes active.
- `div_err`, out, 1, one-cycle pulse when `div_load` carries N < 2 (request ignored).
- `clk_out`, out, 1, divided clock, registered.
- `rise_pulse`, out, 1, one-cycle strobe in the cycle `clk_out` becomes 1.
- `fall_pulse`, out, 1, one-cycle strobe in the cycle `clk_out` becomes 0.
- `period_cnt`, out, `PCNT_W`, count of completed periods; wraps modulo 2^`PCNT_W`.
- `busy`, out, 1, 1 when state != IDLE.

Behaviour:
- **Reset** (`rst`=1 at an edge): the following registers take these values.
  - state = IDLE, active N = `DEFAULT_DIV`, pending invalid.
  - Phase counter = 0, `period_cnt` = 0.
  - `clk_out`, `rise_pulse`, `fall_pulse`, `div_ack`, `div_err`, `busy` = 0.
  - Reset mid-period aborts immediately; any pending ratio is discarded.
- **Phase lengths:** H = N>>1 high cycles, L = N−H low cycles.
  - N=2: 1/1. N=5: 2/3. N=255: 127/128.
  - Period = N `clk` cycles.
- **States:** IDLE, HIGH, LOW. All outputs are registered; transitions are listed per edge.
- **IDLE:**
  - If a pending ratio is valid, apply it, pulse `div_ack`, clear pending.
  - Then, if `enable`=1: go to HIGH, `clk_out`<=1, `rise_pulse`<=1, counter<=1.
  - Latency from `enable` sampled high to `clk_out`=1 is 1 cycle. The first period uses the just-applied N.
- **HIGH:**
  - If counter == H: go to LOW, `clk_out`<=0, `fall_pulse`<=1, counter<=1.
  - Otherwise counter++.
- **LOW:**
  - While counter != L: counter++.
  - When counter == L, this is the period boundary:
    - `period_cnt`++.
    - If pending is valid: apply it, pulse `div_ack`, clear pending.
    - If `enable`=1: go to HIGH with `rise_pulse`, counter<=1, using the new N.
    - If `enable`=0: go to IDLE, `clk_out` stays 0.
- **Stopping:** deasserting `enable` mid-period never truncates a period. The final period completes fully.
- **Load handshake:**
  - `div_load` with N >= 2 captures N into pending; `div_ack` follows at the next boundary, or the next edge if IDLE.
  - A second load before the boundary overwrites pending; only one `div_ack` is issued, for the last value.
  - `div_load` with N < 2: `div_err` pulses the next cycle; pending and active N are unchanged.
  - A load in the same cycle as a boundary is captured as pending and applied at the following boundary.
- **Strobes:** `rise_pulse` and `fall_pulse` are never both 1 in the same cycle. For N=2 they alternate every cycle.
- **Counter width:** the phase counter is `CNT_W` bits, so it never overflows because H, L <= 2^(`CNT_W`−1).

Test Plan:
- **Reset then run at N=2:** `rst` for 2 cycles, then `enable`=1.
  - `clk_out` = 1,0,1,0,... toggling every 10 ns, i.e. a 20 ns period.
  - Sampled at t=80 ns after a reset release at 0 with enable, it matches a free-running 50 MHz reference.
  - `period_cnt`=3 after 7 enabled cycles.
- **Odd ratio:** load N=5 while IDLE.
  - `div_ack` pulses 1 cycle later.
  - `clk_out` high 2 cycles, low 3 cycles, repeating.
  - `rise_pulse` period is 5 cycles.
- **Mid-run reload:** running N=4, load N=6 at the 2nd cycle of HIGH.
  - The current period completes at 4 cycles.
  - `div_ack` coincides with the next `rise_pulse`; subsequent periods are 3 high / 3 low.
  - A double load (6 then 8) in one period gives a single `div_ack` and N=8.
- **Illegal ratio:** load N=1, then N=0.
  - `div_err` pulses each time, with no `div_ack`; N=2 output is unchanged.
- **Graceful stop:** N=6, drop `enable` on the 1st HIGH cycle.
  - `clk_out` finishes 3 high + 3 low, then `busy`=0.
  - `period_cnt` increments by exactly 1.
- **Reset mid-operation:** assert `rst` during LOW of N=8 with a pending N=3.
  - Next cycle all outputs are 0 and N=`DEFAULT_DIV`.
  - The re-enabled run uses N=2; no `div_ack` is issued for 3.
